// File: rtl/kronos_pkg.sv
// kronos_pkg: shared rotate-unit opcodes, request/response records and default sizes.
package kronos_pkg;
  localparam int KRONOS_DATA_W    = 32;
  localparam int KRONOS_BUF_DEPTH = 4;
  localparam int KRONOS_SHAMT_W   = $clog2(2 * KRONOS_DATA_W);
  typedef enum logic [1:0] {
    OP_NOP    = 2'd0,
    OP_ROL_LO = 2'd1,
    OP_ROL_HI = 2'd2,
    OP_FLUSH  = 2'd3
  } rot_op_e;
  typedef struct packed {
    rot_op_e                     op;
    logic [KRONOS_DATA_W-1:0]    hi;
    logic [KRONOS_DATA_W-1:0]    lo;
    logic [KRONOS_SHAMT_W-1:0]   shamt;
  } rot_req_t;
  typedef struct packed {
    logic [KRONOS_DATA_W-1:0] data;
    logic                     err;
  } rot_resp_t;
endpackage

// File: rtl/kronos_rot_buf.sv
// kronos_rot_buf: circular FIFO holding pending high words; push/pop are ignored when full/empty.
module kronos_rot_buf #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     clr_i,
  input  logic [W-1:0]             data_i,
  output logic [W-1:0]             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;
  assign full_o  = count == (AW+1)'(DEPTH);
  assign empty_o = count == '0;
  assign count_o = count;
  assign data_o  = mem[rd_ptr];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  always_ff @(posedge clk_i)
    if (do_push && !clr_i) mem[wr_ptr] <= data_i;
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i || clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (do_push) begin
      wr_ptr <= wr_ptr + 1'b1;
      count  <= count + 1'b1;
    end else if (do_pop) begin
      rd_ptr <= rd_ptr + 1'b1;
      count  <= count - 1'b1;
    end
endmodule

// File: rtl/kronos_rot_unit.sv
// kronos_rot_unit: 2*DATA_W rotate-left, low word returned now, high word queued for ROL_HI.
// Define KRONOS_ROT_PERF_EN to add saturating stall/error counters.
module kronos_rot_unit
  import kronos_pkg::*;
#(
  parameter int DATA_W    = KRONOS_DATA_W,
  parameter int BUF_DEPTH = KRONOS_BUF_DEPTH,
  parameter int SHAMT_W   = $clog2(2 * DATA_W)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [1:0]                   req_op_i,
  input  logic [DATA_W-1:0]            req_hi_i,
  input  logic [DATA_W-1:0]            req_lo_i,
  input  logic [SHAMT_W-1:0]           req_shamt_i,
  output logic                         resp_valid_o,
  input  logic                         resp_ready_i,
  output logic [DATA_W-1:0]            resp_data_o,
  output logic                         resp_err_o,
`ifdef KRONOS_ROT_PERF_EN
  output logic [15:0]                  perf_stall_o,
  output logic [15:0]                  perf_err_o,
  output logic [$clog2(BUF_DEPTH):0]   buf_count_o
`else
  output logic [$clog2(BUF_DEPTH):0]   buf_count_o
`endif
);
  rot_op_e                 op;
  logic                    accept;
  logic [2*DATA_W-1:0]     opnd, rot;
  logic [4*DATA_W-1:0]     dbl;
  logic [DATA_W-1:0]       buf_data, nxt_data;
  logic                    buf_full, buf_empty, nxt_err;
  assign op          = rot_op_e'(req_op_i);
  assign req_ready_o = !resp_valid_o || resp_ready_i;
  assign accept      = req_valid_i && req_ready_o;
  // Rotating by shifting a doubled copy avoids a shift by the full width at shamt=0.
  assign opnd = {req_hi_i, req_lo_i};
  assign dbl  = {opnd, opnd} << req_shamt_i;
  assign rot  = dbl[4*DATA_W-1:2*DATA_W];
  kronos_rot_buf #(.W(DATA_W), .DEPTH(BUF_DEPTH)) u_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept && op == OP_ROL_LO),
    .pop_i   (accept && op == OP_ROL_HI),
    .clr_i   (accept && op == OP_FLUSH),
    .data_i  (rot[2*DATA_W-1:DATA_W]),
    .data_o  (buf_data),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_count_o)
  );
  always_comb begin
    nxt_data = op == OP_ROL_LO ? rot[DATA_W-1:0] :
               op == OP_ROL_HI ? (buf_empty ? '0 : buf_data) :
               op == OP_FLUSH  ? DATA_W'(buf_count_o) : '0;
    nxt_err  = (op == OP_ROL_LO && buf_full) || (op == OP_ROL_HI && buf_empty);
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      resp_valid_o <= 1'b0;
      resp_data_o  <= '0;
      resp_err_o   <= 1'b0;
    end else if (accept) begin
      resp_valid_o <= op != OP_NOP;
      if (op != OP_NOP) begin
        resp_data_o <= nxt_data;
        resp_err_o  <= nxt_err;
      end
    end else if (resp_ready_i) begin
      resp_valid_o <= 1'b0;
    end
`ifdef KRONOS_ROT_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i || (accept && op == OP_FLUSH)) begin
      perf_stall_o <= '0;
      perf_err_o   <= '0;
    end else begin
      if (req_valid_i && !req_ready_o && perf_stall_o != 16'hFFFF) perf_stall_o <= perf_stall_o + 1'b1;
      if (accept && op != OP_NOP && nxt_err && perf_err_o != 16'hFFFF) perf_err_o <= perf_err_o + 1'b1;
    end
`endif
endmodule

// File: tb/tb_kronos_rot_unit.sv
// tb_kronos_rot_unit: directed vectors with a queue scoreboard checked by a response monitor.
module tb_kronos_rot_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, resp_valid, resp_ready, resp_err;
  logic [1:0]  req_op;
  logic [31:0] req_hi, req_lo, resp_data;
  logic [5:0]  req_shamt;
  logic [2:0]  buf_count;
`ifdef KRONOS_ROT_PERF_EN
  logic [15:0] perf_stall, perf_err;
`endif
  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];
  always #5 clk = ~clk;
  kronos_rot_unit dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_op_i     (req_op),
    .req_hi_i     (req_hi),
    .req_lo_i     (req_lo),
    .req_shamt_i  (req_shamt),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data),
    .resp_err_o   (resp_err),
`ifdef KRONOS_ROT_PERF_EN
    .perf_stall_o (perf_stall),
    .perf_err_o   (perf_err),
`endif
    .buf_count_o  (buf_count)
  );
  function automatic void chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction
  always @(negedge clk)
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got %h with no expectation", {resp_err, resp_data});
      end else chk("resp", {resp_err, resp_data}, exp_q.pop_front());
    end
  task automatic send(input logic [1:0] op, input logic [31:0] hi, input logic [31:0] lo,
                      input logic [5:0] sh, input logic [31:0] ed, input logic ee);
    req_valid = 1'b1;
    req_op    = op;
    req_hi    = hi;
    req_lo    = lo;
    req_shamt = sh;
    if (op != 2'd0) exp_q.push_back({ee, ed});
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = '0;
    req_hi = '0;
    req_lo = '0;
    req_shamt = '0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 33'(resp_valid), 33'd0);
    chk("rst_resp", {resp_err, resp_data}, 33'd0);
    chk("rst_count", 33'(buf_count), 33'd0);
    chk("rst_ready", 33'(req_ready), 33'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(2'd1, 32'h12345678, 32'h9ABCDEF0, 6'd8, 32'hBCDEF012, 1'b0);
    chk("count_lo8", 33'(buf_count), 33'd1);
    send(2'd2, 32'h0, 32'h0, 6'd0, 32'h3456789A, 1'b0);
    chk("count_hi8", 33'(buf_count), 33'd0);
    send(2'd1, 32'h12345678, 32'h9ABCDEF0, 6'd0, 32'h9ABCDEF0, 1'b0);
    send(2'd2, 32'h0, 32'h0, 6'd0, 32'h12345678, 1'b0);
    send(2'd1, 32'h12345678, 32'h9ABCDEF0, 6'd32, 32'h12345678, 1'b0);
    send(2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd5, 32'h9ABCDEF0, 1'b0);
    send(2'd1, 32'h12345678, 32'h9ABCDEF0, 6'd63, 32'h4D5E6F78, 1'b0);
    send(2'd2, 32'h0, 32'h0, 6'd0, 32'h091A2B3C, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      send(2'd1, 32'hA0 + 32'(i), 32'(i), 6'd0, 32'(i), i == 5);
      if (i >= 4) chk("count_full", 33'(buf_count), 33'd4);
    end
    for (int i = 1; i <= 4; i++) send(2'd2, 32'h0, 32'h0, 6'd0, 32'hA0 + 32'(i), 1'b0);
    chk("count_drained", 33'(buf_count), 33'd0);
    send(2'd3, 32'h0, 32'h0, 6'd0, 32'h0, 1'b0);
    send(2'd2, 32'h0, 32'h0, 6'd0, 32'h0, 1'b1);
    chk("count_underflow", 33'(buf_count), 33'd0);
`ifdef KRONOS_ROT_PERF_EN
    chk("perf_err", 33'(perf_err), 33'd1);
`endif
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_valid", 33'(resp_valid), 33'd0);
    resp_ready = 1'b0;
    send(2'd1, 32'h55, 32'h66, 6'd0, 32'h66, 1'b0);
    req_op = 2'd2;
    exp_q.push_back({1'b0, 32'h55});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("stall_ready", 33'(req_ready), 33'd0);
      chk("stall_hold", {resp_err, resp_data}, {1'b0, 32'h66});
    end
`ifdef KRONOS_ROT_PERF_EN
    chk("perf_stall", 33'(perf_stall), 33'd3);
`endif
    resp_ready = 1'b1;
    #1;
    chk("release_ready", 33'(req_ready), 33'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("count_after_stall", 33'(buf_count), 33'd0);
    send(2'd1, 32'h1, 32'h2, 6'd0, 32'h2, 1'b0);
    send(2'd1, 32'h3, 32'h4, 6'd0, 32'h4, 1'b0);
    send(2'd3, 32'h0, 32'h0, 6'd0, 32'h2, 1'b0);
    chk("count_flush", 33'(buf_count), 33'd0);
    send(2'd1, 32'h7, 32'h8, 6'd0, 32'h8, 1'b0);
    req_hi = 32'h9;
    req_lo = 32'hA;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 33'(resp_valid), 33'd0);
    chk("async_rst_count", 33'(buf_count), 33'd0);
    exp_q.delete();
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("q_drain", 33'(exp_q.size()), 33'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
